cunit_pipe: RTL
===============

Name: cunit_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle MIPS control unit.
- Decodes the ID-stage opcode into a control bundle, then carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Each stage's control signals are exposed to the datapath.
- Adds load-use hazard detection (stall plus bubble insertion), branch flush and sticky illegal-opcode reporting.

Parameters:
- OP_W, 6, opcode field width.
- REG_W, 5, register-address width.
- AOP_W, 3, ALU-op code width to the ALU control.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- OpIn  in  OP_W  opcode of the instruction in ID.
- IdValid  in  1  ID instruction is valid; 0 means decode as bubble.
- IdRs  in  REG_W  rs field of the ID instruction.
- IdRt  in  REG_W  rt field of the ID instruction.
- BrTaken  in  1  branch in MEM resolved taken (mem_Branch & Zero, from datapath).
- ExRegDs  out  1  EX: 1 = dest rd, 0 = dest rt.
- ExAOp  out  AOP_W  EX: ALU op code.
- ExALUsrc  out  1  EX: 1 = immediate operand.
- MemBranch  out  1  MEM: branch instruction.
- MemMRead  out  1  MEM: data memory read.
- MemMWrite  out  1  MEM: data memory write.
- WbMtoR  out  1  WB: 1 = memory data to register file.
- WbUrw  out  1  WB: register-file write enable.
- Stall  out  1  hold PC and IF/ID this cycle.
- IllegalOp  out  1  sticky: an unknown valid opcode was decoded.

Behaviour:
Decode table (RegDs, ALUsrc, AOp, Branch, MRead, MWrite, MtoR, Urw):
- R 000000: 1, 0, 010, 0, 0, 0, 0, 1
- LW 100011: 0, 1, 011, 0, 1, 0, 1, 1
- SW 101011: 0, 1, 011, 0, 0, 1, 0, 0
- BEQ 000100: 0, 0, 001, 1, 0, 0, 0, 0
- ADDI 001000: 0, 1, 011, 0, 0, 0, 0, 1
- ANDI 001100: 0, 1, 101, 0, 0, 0, 0, 1
- ORI 001101: 0, 1, 110, 0, 0, 0, 0, 1
- SLTI 001010: 0, 1, 100, 0, 0, 0, 0, 1

Bundles and bubbles:
- Bubble = all-zero bundle. No X is ever driven.
- Unknown opcode with IdValid=1 decodes as a bubble and sets IllegalOp on the next edge.
- IllegalOp is cleared only by reset.

Latency and outputs:
- An instruction in ID at cycle n produces Ex* at n+1, Mem* at n+2 and Wb* at n+3.
- All outputs except Stall are registered.

Load-use hazard:
- The ID/EX stage holds MRead and dest-rt internally.
- UsesRt = 1 for R, SW and BEQ.
- Stall = IdValid & idex_MRead & (idex_Rt != 0) & (idex_Rt == IdRs | (UsesRt & idex_Rt == IdRt)) & ~BrTaken.
- On Stall, ID/EX loads a bubble; EX/MEM and MEM/WB advance normally.
- The datapath re-presents the same instruction next cycle.

Flush:
- BrTaken=1 loads bubbles into ID/EX and EX/MEM.
- MEM/WB takes the branch's own bundle.
- Flush overrides Stall, so Stall is 0 while BrTaken=1.

Simultaneous events:
- Stall with an illegal opcode: IllegalOp is not set until the instruction actually advances (not stalled, not flushed).
- A flushed illegal opcode never sets IllegalOp.

Reset:
- Asynchronous on rst_n low, including mid-stall or mid-flush.
- Clears all stage registers, so every output, Stall and IllegalOp read 0.
- Released synchronously to clk by the system.

Optional Feature:
- Macro CUNIT_JUMP_EN.
- Defined:
  - Adds output Jump (1 bit, ID stage, combinational) and decodes J 000010.
  - J gives Jump=1 and a bubble bundle downstream.
  - On a J, Stall is forced to 0.
  - A J in the same cycle as BrTaken gives Jump=0 (the branch wins).
- Undefined: 000010 is illegal, and the Jump port does not exist.

Decomposition:
- Package cunit_pkg holds:
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J;
  - AOp codes AOP_BEQ=001, AOP_RTYPE=010, AOP_ADD=011, AOP_SLT=100, AOP_AND=101, AOP_OR=110;
  - ctrl_t bundle typedef and CTRL_BUBBLE constant.
- Sub-module cunit_dec: purely combinational opcode-to-ctrl_t decoder plus UsesRt and Illegal flags.
- cunit_pipe holds the stage registers, hazard logic and flush logic.

Test Plan:
- Reset check: rst_n low then high, feed R-type (OpIn=000000) -> cycle+1 ExRegDs=1, ExAOp=010; cycle+3 WbUrw=1, WbMtoR=0; all outputs 0 during reset.
- Load-use: LW with rt=5, then ADD with rs=5 -> Stall=1 for exactly one cycle, ExAOp=000 bubble, ADD reaches EX one cycle late with ExAOp=010.
- No false stall: LW rt=0 then ADD rs=0 -> Stall stays 0. LW rt=5 then ADDI rt=5, rs=3 -> Stall=0 (rt unused).
- Flush: BEQ, LW, SW back-to-back, BrTaken=1 when BEQ is in MEM -> next cycle MemMRead=0 and MemMWrite=0 (both flushed), WbUrw=0.
- Illegal: OpIn=111111 with IdValid=1 -> IllegalOp=1 next edge and stays 1 after legal ops; same opcode with IdValid=0 -> stays 0; rst_n pulse clears it.
- Reset mid-stall: assert rst_n=0 while Stall=1 -> Stall and all stage outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/cunit_pkg.sv
// Shared opcodes, ALU-op codes and per-stage control bundles for the pipelined control unit.
// Optional J decode is enabled by CUNIT_JUMP_EN (see cunit_dec / cunit_pipe).
package cunit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] AOP_NONE  = 3'b000;
  localparam logic [2:0] AOP_BEQ   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;
  localparam logic [2:0] AOP_ADD   = 3'b011;
  localparam logic [2:0] AOP_SLT   = 3'b100;
  localparam logic [2:0] AOP_AND   = 3'b101;
  localparam logic [2:0] AOP_OR    = 3'b110;

  typedef struct packed {
    logic       reg_ds;
    logic       alu_src;
    logic [2:0] aop;
    logic       branch;
    logic       mread;
    logic       mwrite;
    logic       mto_r;
    logic       urw;
  } ctrl_t;

  typedef struct packed {
    logic branch;
    logic mread;
    logic mwrite;
    logic mto_r;
    logic urw;
  } mem_ctrl_t;

  typedef struct packed {
    logic mto_r;
    logic urw;
  } wb_ctrl_t;

  localparam ctrl_t     CTRL_BUBBLE = '0;
  localparam mem_ctrl_t MEM_BUBBLE  = '0;

  function automatic ctrl_t mk_ctrl(input logic reg_ds, input logic alu_src,
                                    input logic [2:0] aop, input logic branch,
                                    input logic mread, input logic mwrite,
                                    input logic mto_r, input logic urw);
    ctrl_t c;
    c.reg_ds  = reg_ds;
    c.alu_src = alu_src;
    c.aop     = aop;
    c.branch  = branch;
    c.mread   = mread;
    c.mwrite  = mwrite;
    c.mto_r   = mto_r;
    c.urw     = urw;
    return c;
  endfunction

  function automatic mem_ctrl_t to_mem(input ctrl_t c);
    mem_ctrl_t m;
    m.branch = c.branch;
    m.mread  = c.mread;
    m.mwrite = c.mwrite;
    m.mto_r  = c.mto_r;
    m.urw    = c.urw;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
    wb_ctrl_t w;
    w.mto_r = m.mto_r;
    w.urw   = m.urw;
    return w;
  endfunction

endpackage

// File: rtl/cunit_dec.sv
// Combinational opcode decoder: control bundle, rt-usage and illegal-opcode flags.
// With CUNIT_JUMP_EN defined, J is decoded and reported on jump; otherwise J is illegal.
module cunit_dec
  import cunit_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  input  logic            valid,
  output ctrl_t           ctrl,
  output logic            uses_rt,
  output logic            illegal
`ifdef CUNIT_JUMP_EN
  ,
  output logic            jump
`endif
);

  logic known;
  logic is_j;

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    uses_rt = 1'b0;
    known   = 1'b1;
    is_j    = 1'b0;
    case (op)
      OP_W'(OP_RTYPE): begin
        ctrl    = mk_ctrl(1'b1, 1'b0, AOP_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        uses_rt = 1'b1;
      end
      OP_W'(OP_LW):   ctrl = mk_ctrl(1'b0, 1'b1, AOP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      OP_W'(OP_SW): begin
        ctrl    = mk_ctrl(1'b0, 1'b1, AOP_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        uses_rt = 1'b1;
      end
      OP_W'(OP_BEQ): begin
        ctrl    = mk_ctrl(1'b0, 1'b0, AOP_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        uses_rt = 1'b1;
      end
      OP_W'(OP_ADDI): ctrl = mk_ctrl(1'b0, 1'b1, AOP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      OP_W'(OP_ANDI): ctrl = mk_ctrl(1'b0, 1'b1, AOP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      OP_W'(OP_ORI):  ctrl = mk_ctrl(1'b0, 1'b1, AOP_OR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      OP_W'(OP_SLTI): ctrl = mk_ctrl(1'b0, 1'b1, AOP_SLT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CUNIT_JUMP_EN
      OP_W'(OP_J):    is_j = 1'b1;
`endif
      default:        known = 1'b0;
    endcase

    // An invalid slot is a bubble regardless of what the opcode bits hold.
    if (!valid) begin
      ctrl    = CTRL_BUBBLE;
      uses_rt = 1'b0;
      known   = 1'b1;
      is_j    = 1'b0;
    end
  end

  assign illegal = valid & ~known;

`ifdef CUNIT_JUMP_EN
  assign jump = is_j;
`else
  logic unused_j;
  assign unused_j = is_j;
`endif

endmodule

// File: rtl/cunit_pipe.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush and sticky illegal-opcode flag. Optional J via CUNIT_JUMP_EN.
module cunit_pipe
  import cunit_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int REG_W = 5,
  parameter int AOP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  OpIn,
  input  logic             IdValid,
  input  logic [REG_W-1:0] IdRs,
  input  logic [REG_W-1:0] IdRt,
  input  logic             BrTaken,
  output logic             ExRegDs,
  output logic [AOP_W-1:0] ExAOp,
  output logic             ExALUsrc,
  output logic             MemBranch,
  output logic             MemMRead,
  output logic             MemMWrite,
  output logic             WbMtoR,
  output logic             WbUrw,
  output logic             Stall,
  output logic             IllegalOp
`ifdef CUNIT_JUMP_EN
  ,
  output logic             Jump
`endif
);

  ctrl_t            dec_ctrl;
  logic             dec_uses_rt;
  logic             dec_illegal;
  ctrl_t            idex;
  logic [REG_W-1:0] idex_rt;
  mem_ctrl_t        exmem;
  wb_ctrl_t         memwb;
  logic             ill_q;
  logic             rt_hit;
  logic             stall;
  logic             idex_hold;

`ifdef CUNIT_JUMP_EN
  logic dec_jump;
`endif

  cunit_dec #(
    .OP_W(OP_W)
  ) u_dec (
    .op      (OpIn),
    .valid   (IdValid),
    .ctrl    (dec_ctrl),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal)
`ifdef CUNIT_JUMP_EN
    ,
    .jump    (dec_jump)
`endif
  );

  // Flush has priority over the load-use stall.
  always_comb begin
    rt_hit = (idex_rt != '0) &&
             ((idex_rt == IdRs) || (dec_uses_rt && (idex_rt == IdRt)));
    stall  = IdValid & idex.mread & rt_hit & ~BrTaken;
`ifdef CUNIT_JUMP_EN
    stall  = stall & ~dec_jump;
`endif
    idex_hold = stall | BrTaken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex    <= CTRL_BUBBLE;
      idex_rt <= '0;
    end else if (idex_hold) begin
      idex    <= CTRL_BUBBLE;
      idex_rt <= '0;
    end else begin
      idex    <= dec_ctrl;
      idex_rt <= IdRt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem <= MEM_BUBBLE;
    end else if (BrTaken) begin
      exmem <= MEM_BUBBLE;
    end else begin
      exmem <= to_mem(idex);
    end
  end

  // MEM/WB keeps the resolving branch's own bundle even on a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb <= '0;
    end else begin
      memwb <= to_wb(exmem);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else if (dec_illegal && !idex_hold) begin
      ill_q <= 1'b1;
    end
  end

  assign ExRegDs   = idex.reg_ds;
  assign ExAOp     = AOP_W'(idex.aop);
  assign ExALUsrc  = idex.alu_src;
  assign MemBranch = exmem.branch;
  assign MemMRead  = exmem.mread;
  assign MemMWrite = exmem.mwrite;
  assign WbMtoR    = memwb.mto_r;
  assign WbUrw     = memwb.urw;
  assign Stall     = stall;
  assign IllegalOp = ill_q;

`ifdef CUNIT_JUMP_EN
  assign Jump = dec_jump & ~BrTaken;
`endif

endmodule
